// File: rtl/mux_rr_stream.sv
// -----------------------------------------------------------------------------
// mux_rr_stream
//   N-channel, WIDTH-bit stream multiplexer with a valid/ready handshake on
//   every channel and a single registered output beat. Each transfer picks a
//   channel in one of two ways:
//   - fixed mode: the channel named by sel;
//   - round-robin mode: the first valid channel after the last granted one.
//   Every output beat carries the index of its source channel.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   mode      0 = fixed select, 1 = round-robin
//   sel       channel index used in fixed mode
//   in_data   packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready, at most one bit high (combinational)
//   out_data  registered output data
//   out_ch    registered index of the channel that sourced out_data
//   out_valid registered output beat valid
//   out_ready consumer ready
// -----------------------------------------------------------------------------
module mux_rr_stream #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Channel count widened by one bit so that any sel value can be range checked.
  localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);
  // After reset the last grant is the top channel, so channel 0 goes first.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_CH - 1);

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0]     out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]     last_grant_q, last_grant_d;

  logic                 load_en_s;
  logic                 sel_in_range_s;
  logic                 fix_found_s;
  logic [SEL_W:0]       rr_pick_s;
  logic                 gnt_found_s;
  logic [SEL_W-1:0]     gnt_s;
  logic [WIDTH-1:0]     gnt_data_s;
  logic                 xfer_s;
  logic [N_CH-1:0]      in_ready_s;

  // Round-robin search. It walks the offsets from farthest to nearest, so the
  // nearest valid channel after 'last' is written last and wins.
  // The result is {found, index}.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_CH-1:0]  valid,
                                             input logic [SEL_W-1:0] last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    int               pos;
    res = '0;
    for (int k = N_CH; k >= 1; k--) begin
      pos = (int'(last) + k) % N_CH;
      idx = pos[SEL_W-1:0];
      if (valid[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Compute the load enable and the grant decision for the current cycle.
  always_comb begin
    load_en_s      = !out_valid_q || out_ready;
    sel_in_range_s = ({1'b0, sel} < N_CH_W);
    fix_found_s    = sel_in_range_s && in_valid[sel];
    rr_pick_s      = rr_pick(in_valid, last_grant_q);
    gnt_found_s    = 1'b0;
    gnt_s          = '0;
    if (mode) begin
      gnt_found_s = rr_pick_s[SEL_W];
      gnt_s       = rr_pick_s[SEL_W-1:0];
    end else begin
      gnt_found_s = fix_found_s;
      gnt_s       = sel;
    end
  end

  // Data mux for the granted channel. It is built from explicit compares so
  // that an out-of-range index selects zero instead of X.
  always_comb begin
    gnt_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_s == SEL_W'(i)) begin
        gnt_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // One-hot ready decode. It is held low during reset and when there is no
  // grant or no room in the output register.
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rst_n && load_en_s && gnt_found_s && (gnt_s == SEL_W'(i))) begin
        in_ready_s[i] = 1'b1;
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for the output register and the round-robin pointer.
  // A new beat has priority over draining, which gives one beat per cycle.
  always_comb begin
    xfer_s       = load_en_s && gnt_found_s;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (xfer_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = gnt_data_s;
      out_ch_d     = gnt_s;
      last_grant_d = gnt_s;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // State registers for the output beat and the last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_stream
//   Scoreboard bench for mux_rr_stream with N_CH=4 and WIDTH=8. A small
//   reference model predicts the grant and in_ready for each cycle. Accepted
//   beats are pushed to a queue. Each output beat is popped from the queue
//   when the consumer takes it, and compared there.
// -----------------------------------------------------------------------------
module tb_mux_rr_stream;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int          n_checks;
  int          n_fail;

  // Reference model state
  logic        m_valid;
  logic [1:0]  m_last;
  logic [9:0]  sb [$];   // {ch, data}
  logic [31:0] din;

  mux_rr_stream #(.N_CH(4), .WIDTH(8), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge. It drives one cycle of stimulus, checks the
  // outputs against the model, updates the model, and returns at the next
  // falling edge.
  task automatic step(input logic [3:0] v, input logic m, input logic [1:0] s,
                      input logic ordy);
    logic       found;
    logic       load;
    logic [1:0] g;
    logic [3:0] exp_rdy;
    logic [9:0] beat;
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    in_data   = din;
    #1;
    load  = !m_valid || ordy;
    found = 1'b0;
    g     = 2'd0;
    if (!m) begin
      if (v[s]) begin
        found = 1'b1;
        g     = s;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (int'(m_last) + k) % 4;
        if (!found && v[c]) begin
          found = 1'b1;
          g     = c[1:0];
        end
      end
    end
    exp_rdy = (found && load) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        beat = ordy ? sb.pop_front() : sb[0];
        chk("out_ch", {30'd0, out_ch}, {30'd0, beat[9:8]});
        chk("out_data", {24'd0, out_data}, {24'd0, beat[7:0]});
      end
    end
    if (found && load) begin
      sb.push_back({g, din[g*8 +: 8]});
      m_last  = g;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge. It resets both the DUT and the model.
  task automatic do_reset();
    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_last  = 2'd3;
    sb.delete();
    @(negedge clk);
    rst_n   = 1'b1;
  endtask

  logic [7:0] t1_d  [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [1:0] t2_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] t3_ch [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 32'd0;
    in_valid  = 4'd0;
    out_ready = 1'b0;
    n_checks  = 0;
    n_fail    = 0;
    m_valid   = 1'b0;
    m_last    = 2'd3;
    din       = 32'hD3C2B1A0;

    // Values while reset is held
    #1;
    in_valid = 4'hF;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: fixed mode, sel stepped 0..3
    for (int i = 0; i < 4; i++) begin
      step(4'hF, 1'b0, i[1:0], 1'b1);
      chk("t1_data", {24'd0, out_data}, {24'd0, t1_d[i]});
      chk("t1_ch", {30'd0, out_ch}, i);
    end
    step(4'h0, 1'b0, 2'd0, 1'b1);

    // 2: round-robin, all valid, random data
    do_reset();
    for (int i = 0; i < 6; i++) begin
      din = $urandom();
      step(4'hF, 1'b1, 2'd0, 1'b1);
      chk("t2_ch", {30'd0, out_ch}, {30'd0, t2_ch[i]});
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
    end
    step(4'h0, 1'b1, 2'd0, 1'b1);

    // 3: round-robin with in_valid = 1010
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din = $urandom();
      step(4'b1010, 1'b1, 2'd0, 1'b1);
      chk("t3_ch", {30'd0, out_ch}, {30'd0, t3_ch[i]});
    end
    step(4'h0, 1'b1, 2'd0, 1'b1);

    // 4: backpressure holding the channel-2 beat
    do_reset();
    din = 32'hD3C2B1A0;
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b1, 2'd0, 1'b0);
      chk("t4_hold_data", {24'd0, out_data}, 32'hC2);
      chk("t4_hold_ch", {30'd0, out_ch}, 32'd2);
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    step(4'hF, 1'b1, 2'd0, 1'b1);
    chk("t4_next_ch", {30'd0, out_ch}, 32'd3);

    // 5: fixed sel=1 with channel 1 idle, then switch to round-robin
    step(4'b1101, 1'b0, 2'd1, 1'b1);
    chk("t5_drained", {31'd0, out_valid}, 32'd0);
    step(4'b1101, 1'b0, 2'd1, 1'b1);
    chk("t5_idle", {31'd0, out_valid}, 32'd0);
    step(4'b1101, 1'b1, 2'd1, 1'b1);
    chk("t5_rr_ch", {30'd0, out_ch}, 32'd0);
    chk("t5_rr_valid", {31'd0, out_valid}, 32'd1);

    // 6: asynchronous reset in the middle of a cycle while a beat is held
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_data", {24'd0, out_data}, 32'd0);
    chk("t6_ch", {30'd0, out_ch}, 32'd0);
    chk("t6_ready", {28'd0, in_ready}, 32'd0);
    m_valid = 1'b0;
    m_last  = 2'd3;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 2'd3;
    step(4'hF, 1'b1, 2'd2, 1'b1);
    chk("t6_first_ch", {30'd0, out_ch}, 32'd0);
    step(4'h0, 1'b1, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
